la_uart_tx: RTL and testbench

Serial readout stage for the logic analyzer's protocol capture FIFO. It drains 16-bit capture words through the FIFO's pop handshake and sends each word as two 8N1 UART bytes, high byte first, on a single output pin. This gives the host a continuous stream of decoded bytes without bit-banging the FIFO read strobe. It sits directly downstream of the capture FIFO and replaces manual pops on the bidirectional pins.

---
 rtl/la_pkg.sv | 31 +++
 rtl/la_baud_tick.sv | 32 +++
 rtl/la_uart_tx.sv | 180 ++++++++++++++++++
 tb/tb_la_uart_tx.sv | 300 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/la_pkg.sv
// la_pkg: shared definitions for the logic analyzer readout path.
//   - la_tx_state_t : UART transmitter FSM states
//   - LA_WORD_W, LA_PROTO_MSB/LSB : capture word layout
//   - LA_PROTO_* : proto_id encodings carried in word[15:14]
//   - la_hi_byte() : first byte sent on the wire, {proto_id, 6'b0}
package la_pkg;

  localparam int LA_WORD_W    = 16;
  localparam int LA_PROTO_MSB = 15;
  localparam int LA_PROTO_LSB = 14;

  localparam logic [1:0] LA_PROTO_UART = 2'd0;
  localparam logic [1:0] LA_PROTO_SPI  = 2'd1;
  localparam logic [1:0] LA_PROTO_I2C  = 2'd2;
  localparam logic [1:0] LA_PROTO_NONE = 2'd3;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    LOAD   = 3'd1,
    START  = 3'd2,
    DATA   = 3'd3,
    PARITY = 3'd4,
    STOP   = 3'd5
  } la_tx_state_t;

  // Reserved bits [13:8] never reach the wire; they are replaced by zeros.
  function automatic logic [7:0] la_hi_byte(input logic [1:0] proto);
    return {proto, 6'b0};
  endfunction

endpackage

// File: rtl/la_baud_tick.sv
// la_baud_tick: bit-period timer for la_uart_tx.
//   clk     : clock, rising edge
//   rst     : synchronous active-high reset
//   restart : forces the counter back to 0 (asserted on every FSM state change)
//   tick    : high on the last clock of a bit period (count == CLKS_PER_BIT-1)
module la_baud_tick #(
  parameter int CLKS_PER_BIT = 16
) (
  input  logic clk,
  input  logic rst,
  input  logic restart,
  output logic tick
);

  localparam int CNT_W = $clog2(CLKS_PER_BIT);
  localparam logic [CNT_W-1:0] LAST = CNT_W'(CLKS_PER_BIT - 1);

  logic [CNT_W-1:0] r_cnt;

  always_ff @(posedge clk) begin
    if (rst || restart) begin
      r_cnt <= '0;
    end else if (r_cnt == LAST) begin
      r_cnt <= '0;
    end else begin
      r_cnt <= r_cnt + CNT_W'(1);
    end
  end

  assign tick = (r_cnt == LAST);

endmodule

// File: rtl/la_uart_tx.sv
// la_uart_tx: drains 16-bit capture words from a show-ahead FIFO and sends
// each word as two UART bytes, high byte ({proto_id, 6'b0}) first, then
// the data byte. Framing is 8N1; with LA_UART_TX_PARITY_EN defined an even
// parity bit is inserted between the data bits and the stop bit.
//
// Ports:
//   clk, rst          : clock and synchronous active-high reset
//   enable            : allows new words to be popped (never aborts a word)
//   fifo_valid        : FIFO non-empty, fifo_word is the head word
//   fifo_word[15:0]   : head word {proto_id[1:0], reserved[5:0], data[7:0]}
//   fifo_rd           : one-cycle pop strobe, only ever asserted in IDLE
//   tx                : UART line, idles high
//   busy              : high from the cycle after the pop until back in IDLE
//   words_sent[7:0]   : completed words, wraps modulo 256
//   dbg_state         : current FSM state
//
// Handshake: the pop happens on the rising edge where fifo_valid && fifo_rd
// are both high; fifo_rd is combinational from IDLE && enable && fifo_valid,
// so the word is taken in the same cycle it is offered.
module la_uart_tx
  import la_pkg::*;
#(
  parameter int CLKS_PER_BIT = 16
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 enable,
  input  logic                 fifo_valid,
  input  logic [LA_WORD_W-1:0] fifo_word,
  output logic                 fifo_rd,
  output logic                 tx,
  output logic                 busy,
  output logic [7:0]           words_sent,
  output la_tx_state_t         dbg_state
);

  if (CLKS_PER_BIT < 2 || CLKS_PER_BIT > 65535) begin : g_bad_clks_per_bit
    $error("la_uart_tx: CLKS_PER_BIT must be in 2..65535");
  end

  la_tx_state_t r_state;
  la_tx_state_t w_next;

  logic [1:0] r_proto;
  logic [7:0] r_data;
  logic [7:0] r_shift;
  logic [2:0] r_bit_cnt;
  logic       r_byte_sel;
  logic [7:0] r_words_sent;
  logic       w_tick;
  logic       w_restart;
  logic       w_unused_rsvd;

`ifdef LA_UART_TX_PARITY_EN
  logic       r_parity;
`endif

  assign w_unused_rsvd = ^fifo_word[13:8];

  // Every state entry restarts the bit period.
  assign w_restart = (w_next != r_state);

  la_baud_tick #(
    .CLKS_PER_BIT(CLKS_PER_BIT)
  ) u_baud (
    .clk     (clk),
    .rst     (rst),
    .restart (w_restart),
    .tick    (w_tick)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  always_comb begin
    w_next  = r_state;
    fifo_rd = 1'b0;
    tx      = 1'b1;
    case (r_state)
      IDLE: begin
        // Gated by rst so nothing is popped while reset is held.
        if (enable && fifo_valid && !rst) begin
          fifo_rd = 1'b1;
          w_next  = LOAD;
        end
      end
      LOAD: begin
        w_next = START;
      end
      START: begin
        tx = 1'b0;
        if (w_tick) w_next = DATA;
      end
      DATA: begin
        tx = r_shift[0];
        if (w_tick && (r_bit_cnt == 3'd7)) begin
`ifdef LA_UART_TX_PARITY_EN
          w_next = PARITY;
`else
          w_next = STOP;
`endif
        end
      end
`ifdef LA_UART_TX_PARITY_EN
      PARITY: begin
        tx = r_parity;
        if (w_tick) w_next = STOP;
      end
`endif
      STOP: begin
        if (w_tick) w_next = r_byte_sel ? IDLE : START;
      end
      default: begin
        w_next = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_proto      <= '0;
      r_data       <= '0;
      r_shift      <= '0;
      r_bit_cnt    <= '0;
      r_byte_sel   <= 1'b0;
      r_words_sent <= '0;
`ifdef LA_UART_TX_PARITY_EN
      r_parity     <= 1'b0;
`endif
    end else begin
      case (r_state)
        IDLE: begin
          if (fifo_rd) begin
            r_proto    <= fifo_word[LA_PROTO_MSB:LA_PROTO_LSB];
            r_data     <= fifo_word[7:0];
            r_byte_sel <= 1'b0;
          end
        end
        LOAD: begin
          r_shift   <= la_hi_byte(r_proto);
          r_bit_cnt <= '0;
`ifdef LA_UART_TX_PARITY_EN
          r_parity  <= ^r_proto;
`endif
        end
        DATA: begin
          // Counter wraps 7 -> 0, so it is already clear for the next byte.
          if (w_tick) begin
            r_shift   <= {1'b0, r_shift[7:1]};
            r_bit_cnt <= r_bit_cnt + 3'd1;
          end
        end
        STOP: begin
          if (w_tick) begin
            if (!r_byte_sel) begin
              r_byte_sel <= 1'b1;
              r_shift    <= r_data;
`ifdef LA_UART_TX_PARITY_EN
              r_parity   <= ^r_data;
`endif
            end else begin
              r_words_sent <= r_words_sent + 8'd1;
            end
          end
        end
        default: ;
      endcase
    end
  end

  assign busy       = (r_state != IDLE);
  assign words_sent = r_words_sent;
  assign dbg_state  = r_state;

endmodule

// File: tb/tb_la_uart_tx.sv
module tb_la_uart_tx;
  import la_pkg::*;

  localparam int CPB = 4;
`ifdef LA_UART_TX_PARITY_EN
  localparam int NB = 11;
`else
  localparam int NB = 10;
`endif
  localparam int WORD_CYC = 2 + 2 * NB * CPB;

  logic         clk;
  logic         rst;
  logic         enable;
  logic         fifo_valid;
  logic [15:0]  fifo_word;
  logic         fifo_rd;
  logic         tx;
  logic         busy;
  logic [7:0]   words_sent;
  la_tx_state_t dbg_state;

  int checks = 0;
  int errors = 0;

  la_uart_tx #(.CLKS_PER_BIT(CPB)) dut (
    .clk        (clk),
    .rst        (rst),
    .enable     (enable),
    .fifo_valid (fifo_valid),
    .fifo_word  (fifo_word),
    .fifo_rd    (fifo_rd),
    .tx         (tx),
    .busy       (busy),
    .words_sent (words_sent),
    .dbg_state  (dbg_state)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // FIFO model: show-ahead queue, popped just after the edge that took fifo_rd
  logic [15:0] fq[$];
  int pops = 0;
  int rd_consec = 0;
  int rd_busy = 0;
  bit prev_rd = 1'b0;
  bit pop_now;

  task automatic drive_fifo();
    fifo_valid = (fq.size() != 0);
    fifo_word  = (fq.size() != 0) ? fq[0] : 16'h0000;
  endtask

  task automatic push_word(input logic [15:0] w);
    fq.push_back(w);
    drive_fifo();
  endtask

  initial begin
    forever begin
      @(negedge clk);
      pop_now = (fifo_rd === 1'b1);
      if (pop_now) begin
        pops++;
        if (prev_rd) rd_consec++;
        if (busy !== 1'b0) rd_busy++;
      end
      prev_rd = pop_now;
      @(posedge clk);
      #1;
      if (pop_now && fq.size() > 0) void'(fq.pop_front());
      drive_fifo();
    end
  end

  // driver tasks (called at a negedge)
  task automatic wait_pop(output bit ok);
    ok = 1'b0;
    for (int i = 0; i < 300; i++) begin
      if (fifo_rd === 1'b1) begin
        ok = 1'b1;
        break;
      end
      @(negedge clk);
    end
  endtask

  // Called at the negedge of the pop cycle; returns at the last stop cycle.
  task automatic recv_word(output logic [15:0] w, output int ferr);
    logic [7:0] b;
    logic v;
    ferr = 0;
    w = '0;
    b = '0;
    v = 1'b0;
    @(negedge clk);
    if (tx !== 1'b1) ferr++;
    for (int by = 0; by < 2; by++) begin
      for (int bi = 0; bi < NB; bi++) begin
        for (int c = 0; c < CPB; c++) begin
          @(negedge clk);
          if (c == 0) v = tx;
          else if (tx !== v) ferr++;
        end
        if (bi == 0) begin
          if (v !== 1'b0) ferr++;
        end else if (bi <= 8) begin
          b[bi-1] = v;
        end else if (bi == NB - 1) begin
          if (v !== 1'b1) ferr++;
        end else begin
          if (v !== ^b) ferr++;
        end
      end
      if (by == 0) w[15:8] = b;
      else w[7:0] = b;
    end
  endtask

  // scenarios
  task automatic test_reset();
    rst = 1'b1;
    enable = 1'b0;
    fifo_valid = 1'b0;
    fifo_word = 16'h0000;
    repeat (3) @(negedge clk);
    checks++; if (tx !== 1'b1) begin errors++; $display("FAIL reset_tx got %b want 1", tx); end
    checks++; if (fifo_rd !== 1'b0) begin errors++; $display("FAIL reset_rd got %b want 0", fifo_rd); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy got %b want 0", busy); end
    checks++; if (words_sent !== 8'd0) begin errors++; $display("FAIL reset_ws got %0d want 0", words_sent); end
    checks++; if (dbg_state !== IDLE) begin errors++; $display("FAIL reset_state got %0d want %0d", dbg_state, IDLE); end
    @(posedge clk); #2;
    rst = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_single();
    bit ok; int p0; int c0; int ferr; logic [15:0] w;
    @(posedge clk); #2;
    p0 = pops;
    push_word(16'h80A5);
    enable = 1'b1;
    @(negedge clk);
    wait_pop(ok);
    checks++; if (!ok) begin errors++; $display("FAIL single_pop got none want pop"); end
    c0 = cyc;
    recv_word(w, ferr);
    checks++; if (w !== 16'h80A5) begin errors++; $display("FAIL single_word got %h want 80a5", w); end
    checks++; if (ferr !== 0) begin errors++; $display("FAIL single_frame got %0d want 0", ferr); end
    checks++; if (busy !== 1'b1) begin errors++; $display("FAIL single_busy_stop got %b want 1", busy); end
    checks++; if (words_sent !== 8'd0) begin errors++; $display("FAIL single_ws_early got %0d want 0", words_sent); end
    @(negedge clk);
    checks++; if (cyc - c0 !== WORD_CYC) begin errors++; $display("FAIL single_period got %0d want %0d", cyc - c0, WORD_CYC); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL single_busy_end got %b want 0", busy); end
    checks++; if (words_sent !== 8'd1) begin errors++; $display("FAIL single_ws got %0d want 1", words_sent); end
    checks++; if (dbg_state !== IDLE) begin errors++; $display("FAIL single_state got %0d want %0d", dbg_state, IDLE); end
    repeat (10) @(negedge clk);
    checks++; if (pops - p0 !== 1) begin errors++; $display("FAIL single_popcount got %0d want 1", pops - p0); end
  endtask

  task automatic test_reserved();
    bit ok; int ferr; logic [15:0] w;
    @(posedge clk); #2;
    push_word(16'hBFFF);
    @(negedge clk);
    wait_pop(ok);
    checks++; if (!ok) begin errors++; $display("FAIL rsvd_pop got none want pop"); end
    recv_word(w, ferr);
    checks++; if (w !== 16'h80FF) begin errors++; $display("FAIL rsvd_word got %h want 80ff", w); end
    checks++; if (ferr !== 0) begin errors++; $display("FAIL rsvd_frame got %0d want 0", ferr); end
    @(negedge clk);
    checks++; if (words_sent !== 8'd2) begin errors++; $display("FAIL rsvd_ws got %0d want 2", words_sent); end
  endtask

  task automatic test_back_to_back();
    logic [15:0] din [3];
    logic [15:0] exp_w [3];
    bit ok; int p0; int prev; int ferr; logic [15:0] w;
    din[0] = 16'h1234; exp_w[0] = 16'h0034;
    din[1] = 16'hC0FF; exp_w[1] = 16'hC0FF;
    din[2] = 16'h4A5A; exp_w[2] = 16'h405A;
    prev = 0;
    @(posedge clk); #2;
    p0 = pops;
    for (int k = 0; k < 3; k++) push_word(din[k]);
    @(negedge clk);
    for (int k = 0; k < 3; k++) begin
      wait_pop(ok);
      checks++; if (!ok) begin errors++; $display("FAIL b2b_pop%0d got none want pop", k); end
      if (k > 0) begin
        checks++; if (cyc - prev !== WORD_CYC) begin errors++; $display("FAIL b2b_spacing%0d got %0d want %0d", k, cyc - prev, WORD_CYC); end
      end
      prev = cyc;
      recv_word(w, ferr);
      checks++; if (w !== exp_w[k]) begin errors++; $display("FAIL b2b_word%0d got %h want %h", k, w, exp_w[k]); end
      checks++; if (ferr !== 0) begin errors++; $display("FAIL b2b_frame%0d got %0d want 0", k, ferr); end
      @(negedge clk);
      checks++; if (tx !== 1'b1) begin errors++; $display("FAIL b2b_idle_tx%0d got %b want 1", k, tx); end
      checks++; if (words_sent !== 8'(3 + k)) begin errors++; $display("FAIL b2b_ws%0d got %0d want %0d", k, words_sent, 3 + k); end
    end
    repeat (10) @(negedge clk);
    checks++; if (pops - p0 !== 3) begin errors++; $display("FAIL b2b_popcount got %0d want 3", pops - p0); end
  endtask

  task automatic test_enable_drop();
    bit ok; int p0; int ferr; logic [15:0] w;
    @(posedge clk); #2;
    p0 = pops;
    push_word(16'h5511);
    push_word(16'h6622);
    enable = 1'b1;
    @(negedge clk);
    wait_pop(ok);
    checks++; if (!ok) begin errors++; $display("FAIL endrop_pop got none want pop"); end
    fork
      recv_word(w, ferr);
      begin
        repeat (10) @(negedge clk);
        enable = 1'b0;
      end
    join
    checks++; if (w !== 16'h4011) begin errors++; $display("FAIL endrop_word got %h want 4011", w); end
    checks++; if (ferr !== 0) begin errors++; $display("FAIL endrop_frame got %0d want 0", ferr); end
    @(negedge clk);
    checks++; if (words_sent !== 8'd6) begin errors++; $display("FAIL endrop_ws got %0d want 6", words_sent); end
    repeat (20) @(negedge clk);
    checks++; if (pops - p0 !== 1) begin errors++; $display("FAIL endrop_popcount got %0d want 1", pops - p0); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL endrop_busy got %b want 0", busy); end
    checks++; if (dbg_state !== IDLE) begin errors++; $display("FAIL endrop_state got %0d want %0d", dbg_state, IDLE); end
  endtask

  task automatic test_reset_mid();
    bit ok; int p0; int ferr; logic [15:0] w;
    // 16'h6622 is still queued from the previous scenario.
    @(posedge clk); #2;
    p0 = pops;
    push_word(16'h9999);
    enable = 1'b1;
    @(negedge clk);
    wait_pop(ok);
    checks++; if (!ok) begin errors++; $display("FAIL rstmid_pop got none want pop"); end
    repeat (19) @(negedge clk);
    checks++; if (dbg_state !== DATA) begin errors++; $display("FAIL rstmid_in_data got %0d want %0d", dbg_state, DATA); end
    rst = 1'b1;
    @(negedge clk);
    checks++; if (tx !== 1'b1) begin errors++; $display("FAIL rstmid_tx got %b want 1", tx); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL rstmid_busy got %b want 0", busy); end
    checks++; if (words_sent !== 8'd0) begin errors++; $display("FAIL rstmid_ws got %0d want 0", words_sent); end
    checks++; if (dbg_state !== IDLE) begin errors++; $display("FAIL rstmid_state got %0d want %0d", dbg_state, IDLE); end
    repeat (4) @(negedge clk);
    checks++; if (pops - p0 !== 1) begin errors++; $display("FAIL rstmid_no_pop got %0d want 1", pops - p0); end
    @(posedge clk); #2;
    rst = 1'b0;
    @(negedge clk);
    wait_pop(ok);
    checks++; if (!ok) begin errors++; $display("FAIL rstmid_repop got none want pop"); end
    recv_word(w, ferr);
    checks++; if (w !== 16'h8099) begin errors++; $display("FAIL rstmid_word got %h want 8099", w); end
    checks++; if (ferr !== 0) begin errors++; $display("FAIL rstmid_frame got %0d want 0", ferr); end
    @(negedge clk);
    checks++; if (words_sent !== 8'd1) begin errors++; $display("FAIL rstmid_ws_after got %0d want 1", words_sent); end
    checks++; if (pops - p0 !== 2) begin errors++; $display("FAIL rstmid_popcount got %0d want 2", pops - p0); end
  endtask

  task automatic test_parity_word();
    bit ok; int c0; int ferr; logic [15:0] w;
    @(posedge clk); #2;
    push_word(16'h0007);
    @(negedge clk);
    wait_pop(ok);
    checks++; if (!ok) begin errors++; $display("FAIL par_pop got none want pop"); end
    c0 = cyc;
    recv_word(w, ferr);
    checks++; if (w !== 16'h0007) begin errors++; $display("FAIL par_word got %h want 0007", w); end
    checks++; if (ferr !== 0) begin errors++; $display("FAIL par_frame got %0d want 0", ferr); end
    @(negedge clk);
    checks++; if (cyc - c0 !== WORD_CYC) begin errors++; $display("FAIL par_period got %0d want %0d", cyc - c0, WORD_CYC); end
    checks++; if (words_sent !== 8'd2) begin errors++; $display("FAIL par_ws got %0d want 2", words_sent); end
  endtask

  initial begin
    test_reset();
    test_single();
    test_reserved();
    test_back_to_back();
    test_enable_drop();
    test_reset_mid();
    test_parity_word();
    checks++; if (rd_consec !== 0) begin errors++; $display("FAIL rd_consecutive got %0d want 0", rd_consec); end
    checks++; if (rd_busy !== 0) begin errors++; $display("FAIL rd_outside_idle got %0d want 0", rd_busy); end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
